merge_crossbar_fifo: RTL
========================

# merge_crossbar_fifo

Routes up to SEG_NUM_IN concurrent input segments to PKT_NUM_OUT per-packet output lanes, keyed on each segment's packet number. It is the buffered successor to the combinational merge crossbar. Each lane holds a FIFO with valid/ready back-pressure, and the block detects same-cycle collisions and out-of-range packet numbers. It sits between the segmented CRC stage and the per-packet go-back/merge logic.

## Interface
- SEG_NUM_IN, 64, number of input segments per beat
- PKT_NUM_OUT, 8, number of output lanes
- DATA_W, 32, segment data width
- PNUM_W, 4, packet-number field width
- ZNUM_W, 12, zero-count field width
- FIFO_DEPTH, 4, entries per lane FIFO; power of two, ≥2
- PKT_BASE, 1, packet-number value mapped to lane 0
- clk  in  1  single clock; all logic is on its rising edge
- rst  in  1  reset, synchronous and active-low
- in_sop / in_eop / in_dval  in  SEG_NUM_IN  per-segment flags
- in_packet_num  in  PNUM_W*SEG_NUM_IN  per-segment packet number
- in_zero_num  in  ZNUM_W*SEG_NUM_IN  per-segment zero count
- in_dout  in  DATA_W*SEG_NUM_IN  per-segment data
- in_ready  out  1  beat accepted when high
- out_ready  in  PKT_NUM_OUT  per-lane consumer ready
- out_sop / out_eop / out_dval  out  PKT_NUM_OUT  lane head flags
- out_packet_num  out  PNUM_W*PKT_NUM_OUT  lane head fields; same for out_zero_num (ZNUM_W), out_dout (DATA_W)
- err_collision  out  PKT_NUM_OUT  1-cycle pulse per lane
- err_range  out  1  1-cycle pulse
- drop_cnt  out  16  saturating count of dropped segments

## Operation
- Segment s is a candidate for lane i when in_dval[s] is high and in_packet_num[s] equals PKT_BASE+i.
- Lane select: the lowest-index candidate wins. Its {sop, eop, packet_num, zero_num, dout} are pushed to lane i's FIFO.
- Collision: if more than one candidate exists for lane i, losers are dropped and err_collision[i] pulses.
- Range: a valid segment with packet_num outside [PKT_BASE, PKT_BASE+PKT_NUM_OUT-1] is dropped and err_range pulses.
- drop_cnt adds the number of dropped segments in the beat (collision losers plus out-of-range), saturating at 0xFFFF.
- Nothing is pushed, counted or flagged unless in_ready is high for that beat.
- in_ready = rst & (every lane count < FIFO_DEPTH). It is all-lanes-not-full, derived from registered counts, with no same-cycle pop credit.
- Lane output is show-ahead: out_dval[i] = FIFO non-empty, and out_* show the head entry. A pop happens when out_dval[i] & out_ready[i].
- Simultaneous push and pop on the same lane leaves the count unchanged; the data order is preserved.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- out_* fields hold their last value when out_dval is low. Consumers qualify them with out_dval only.

## Timing
- Beat accepted at edge N with an empty lane: out_dval[i] high after edge N (visible in cycle N+1). Latency is 1 cycle.
- err_collision, err_range and the drop_cnt update are registered and appear in the cycle after the accepting edge.
- in_ready falls in the cycle after any lane reaches FIFO_DEPTH. It rises in the cycle after that lane pops.
- Reset (rst low at an edge), including mid-operation:
  - all counts and pointers go to 0, and in-flight entries are discarded;
  - out_dval, out_sop, out_eop, err_collision and err_range go to 0, and drop_cnt goes to 0;
  - out_packet_num, out_zero_num and out_dout go to 0;
  - in_ready is 0 while rst is low and 1 in the first cycle after release.
- Input beats offered while in_ready is low are ignored. The upstream stage holds or retries them.

## Structure
- Package merge_xbar_pkg holds:
  - the default widths;
  - the lane entry type {sop, eop, packet_num, zero_num, dout};
  - the drop_cnt width and saturation constant.
- Sub-module merge_crossbar_lane, one instance per lane, takes PKT_NUM_VALUE = PKT_BASE+i. It contains:
  - the priority select and collision detect for its packet number;
  - the FIFO storage, pointers and count;
  - the show-ahead output.
- The top level contains the generate loop, the range check, the in_ready reduction and drop_cnt.

## Test plan
- Reset release: with in_ready high, segment 5 with packet_num 3 and dout 0xA5A5A5A5 is offered -> next cycle out_dval[2]=1, out_dout lane 2 = 0xA5A5A5A5, and all other out_dval are 0.
- Collision: segments 2, 7 and 40 all carry packet_num 1 -> lane 0 receives segment 2's data only, err_collision[0] pulses, and drop_cnt is 2.
- Range: packet_num 0 and packet_num 9 are offered on two segments (PKT_BASE=1, PKT_NUM_OUT=8) -> nothing is pushed, err_range pulses once, and drop_cnt increases by 2.
- Back-pressure: out_ready[4]=0 while 4 beats for packet 5 are pushed -> in_ready is 0 from the cycle after the 4th push. One pop brings in_ready back to 1 the next cycle. Data emerges in order.
- Simultaneous push and pop on a lane holding 2 entries -> count stays at 2 and the head advances by one entry.
- Mid-operation reset: rst is low for one edge with 3 lanes partially full -> all out_dval are 0 and drop_cnt is 0 the next cycle, and in_ready returns to 1 after release.

Source files
------------

// File: rtl/merge_crossbar_fifo_pkg.sv
// Shared widths, lane entry layout and drop counter constants for the
// buffered merge crossbar.
package merge_xbar_pkg;

  localparam int DEF_SEG_NUM_IN  = 64;
  localparam int DEF_PKT_NUM_OUT = 8;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_PKT_BASE    = 1;

  localparam int DATA_W = 32;
  localparam int PNUM_W = 4;
  localparam int ZNUM_W = 12;

  localparam int DROP_W = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [PNUM_W-1:0] packet_num;
    logic [ZNUM_W-1:0] zero_num;
    logic [DATA_W-1:0] dout;
  } lane_entry_t;

endpackage

// File: rtl/merge_crossbar_fifo_if.sv
// Segmented input beat and per-lane show-ahead output bundle of the merge
// crossbar; master is the traffic side, slave is the crossbar.
interface merge_crossbar_fifo_if
  import merge_xbar_pkg::*;
#(
  parameter int SEG_NUM_IN  = DEF_SEG_NUM_IN,
  parameter int PKT_NUM_OUT = DEF_PKT_NUM_OUT
);

  logic [SEG_NUM_IN-1:0]        in_sop;
  logic [SEG_NUM_IN-1:0]        in_eop;
  logic [SEG_NUM_IN-1:0]        in_dval;
  logic [PNUM_W*SEG_NUM_IN-1:0] in_packet_num;
  logic [ZNUM_W*SEG_NUM_IN-1:0] in_zero_num;
  logic [DATA_W*SEG_NUM_IN-1:0] in_dout;
  logic                         in_ready;

  logic [PKT_NUM_OUT-1:0]        out_ready;
  logic [PKT_NUM_OUT-1:0]        out_sop;
  logic [PKT_NUM_OUT-1:0]        out_eop;
  logic [PKT_NUM_OUT-1:0]        out_dval;
  logic [PNUM_W*PKT_NUM_OUT-1:0] out_packet_num;
  logic [ZNUM_W*PKT_NUM_OUT-1:0] out_zero_num;
  logic [DATA_W*PKT_NUM_OUT-1:0] out_dout;

  modport master (
    output in_sop, in_eop, in_dval, in_packet_num, in_zero_num, in_dout,
    input  in_ready,
    output out_ready,
    input  out_sop, out_eop, out_dval, out_packet_num, out_zero_num, out_dout
  );

  modport slave (
    input  in_sop, in_eop, in_dval, in_packet_num, in_zero_num, in_dout,
    output in_ready,
    input  out_ready,
    output out_sop, out_eop, out_dval, out_packet_num, out_zero_num, out_dout
  );

endinterface

// File: rtl/merge_crossbar_fifo_lane.sv
// One output lane: lowest-index segment select for a fixed packet number,
// collision detection, and a show-ahead FIFO with a registered head.
module merge_crossbar_lane
  import merge_xbar_pkg::*;
#(
  parameter int SEG_NUM_IN    = DEF_SEG_NUM_IN,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int PKT_NUM_VALUE = DEF_PKT_BASE,
  localparam int CNT_W        = $clog2(SEG_NUM_IN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_en,
  input  logic [SEG_NUM_IN-1:0]        sop,
  input  logic [SEG_NUM_IN-1:0]        eop,
  input  logic [SEG_NUM_IN-1:0]        dval,
  input  logic [PNUM_W*SEG_NUM_IN-1:0] packet_num,
  input  logic [ZNUM_W*SEG_NUM_IN-1:0] zero_num,
  input  logic [DATA_W*SEG_NUM_IN-1:0] dout,
  input  logic                         pop_ready,
  output lane_entry_t                  head,
  output logic                         head_valid,
  output logic                         full,
  output logic                         err_collision,
  output logic [CNT_W-1:0]             loser_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PNUM_W-1:0] PNUM_MATCH = PNUM_W'(PKT_NUM_VALUE);

  logic [SEG_NUM_IN-1:0] cand;
  logic [CNT_W-1:0]      cand_cnt;
  logic                  any_cand;
  lane_entry_t           push_entry;
  logic                  push;
  logic                  pop;

  lane_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [PTR_W:0]     count;
  logic [PTR_W:0]     count_after_pop;
  logic [PTR_W:0]     count_next;

  // Descending scan so the lowest-index candidate is the last one written.
  always_comb begin
    cand       = '0;
    cand_cnt   = '0;
    push_entry = '0;
    for (int s = SEG_NUM_IN - 1; s >= 0; s--) begin
      cand[s] = dval[s] && (packet_num[s*PNUM_W +: PNUM_W] == PNUM_MATCH);
      if (cand[s]) begin
        push_entry.sop        = sop[s];
        push_entry.eop        = eop[s];
        push_entry.packet_num = packet_num[s*PNUM_W +: PNUM_W];
        push_entry.zero_num   = zero_num[s*ZNUM_W +: ZNUM_W];
        push_entry.dout       = dout[s*DATA_W +: DATA_W];
      end
    end
    for (int s = 0; s < SEG_NUM_IN; s++) begin
      cand_cnt = cand_cnt + CNT_W'(cand[s]);
    end
  end

  assign any_cand  = |cand;
  assign push      = push_en && any_cand;
  assign pop       = head_valid && pop_ready;
  assign loser_cnt = (push_en && any_cand) ? cand_cnt - CNT_W'(1) : '0;
  assign full      = count[PTR_W];

  assign rd_ptr_next     = rd_ptr + PTR_W'(pop);
  assign count_after_pop = count - (PTR_W+1)'(pop);
  assign count_next      = count_after_pop + (PTR_W+1)'(push);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // The head register bypasses storage when the lane drains to empty on the
  // same edge a new entry arrives, and holds its value while the lane is empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      head          <= '0;
      head_valid    <= 1'b0;
      err_collision <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr        <= rd_ptr_next;
      count         <= count_next;
      head_valid    <= (count_next != '0);
      err_collision <= push_en && (cand_cnt > CNT_W'(1));
      if (count_next != '0) begin
        head <= (count_after_pop == '0) ? push_entry : mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/merge_crossbar_fifo.sv
// Buffered merge crossbar: routes segments to per-packet lane FIFOs, flags
// collisions and out-of-range packet numbers, and counts dropped segments.
module merge_crossbar_fifo
  import merge_xbar_pkg::*;
#(
  parameter int SEG_NUM_IN  = DEF_SEG_NUM_IN,
  parameter int PKT_NUM_OUT = DEF_PKT_NUM_OUT,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int PKT_BASE    = DEF_PKT_BASE
) (
  input  logic                     clk,
  input  logic                     rst,
  merge_crossbar_fifo_if.slave     bus,
  output logic [PKT_NUM_OUT-1:0]   err_collision,
  output logic                     err_range,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int CNT_W = $clog2(SEG_NUM_IN + 1);

  lane_entry_t            lane_head   [PKT_NUM_OUT];
  logic [CNT_W-1:0]       lane_losers [PKT_NUM_OUT];
  logic [PKT_NUM_OUT-1:0] lane_valid;
  logic [PKT_NUM_OUT-1:0] lane_full;

  logic [CNT_W-1:0]  range_cnt;
  logic [CNT_W-1:0]  drop_beat;
  logic [DROP_W-1:0] drop_add;

  for (genvar i = 0; i < PKT_NUM_OUT; i++) begin : g_lane
    merge_crossbar_lane #(
      .SEG_NUM_IN    (SEG_NUM_IN),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .PKT_NUM_VALUE (PKT_BASE + i)
    ) u_lane (
      .clk           (clk),
      .rst           (rst),
      .push_en       (bus.in_ready),
      .sop           (bus.in_sop),
      .eop           (bus.in_eop),
      .dval          (bus.in_dval),
      .packet_num    (bus.in_packet_num),
      .zero_num      (bus.in_zero_num),
      .dout          (bus.in_dout),
      .pop_ready     (bus.out_ready[i]),
      .head          (lane_head[i]),
      .head_valid    (lane_valid[i]),
      .full          (lane_full[i]),
      .err_collision (err_collision[i]),
      .loser_cnt     (lane_losers[i])
    );
  end

  assign bus.in_ready = rst && !(|lane_full);

  always_comb begin
    bus.out_dval       = lane_valid;
    bus.out_sop        = '0;
    bus.out_eop        = '0;
    bus.out_packet_num = '0;
    bus.out_zero_num   = '0;
    bus.out_dout       = '0;
    for (int i = 0; i < PKT_NUM_OUT; i++) begin
      bus.out_sop[i]                         = lane_head[i].sop;
      bus.out_eop[i]                         = lane_head[i].eop;
      bus.out_packet_num[i*PNUM_W +: PNUM_W] = lane_head[i].packet_num;
      bus.out_zero_num[i*ZNUM_W +: ZNUM_W]   = lane_head[i].zero_num;
      bus.out_dout[i*DATA_W +: DATA_W]       = lane_head[i].dout;
    end
  end

  // Packet numbers with no lane are dropped here; the lanes never match them.
  always_comb begin
    range_cnt = '0;
    for (int s = 0; s < SEG_NUM_IN; s++) begin
      if (bus.in_dval[s] &&
          ((int'(bus.in_packet_num[s*PNUM_W +: PNUM_W]) < PKT_BASE) ||
           (int'(bus.in_packet_num[s*PNUM_W +: PNUM_W]) > PKT_BASE + PKT_NUM_OUT - 1))) begin
        range_cnt = range_cnt + CNT_W'(1);
      end
    end
    drop_beat = range_cnt;
    for (int i = 0; i < PKT_NUM_OUT; i++) begin
      drop_beat = drop_beat + lane_losers[i];
    end
  end

  assign drop_add = DROP_W'(drop_beat);

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_range <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      err_range <= bus.in_ready && (range_cnt != '0);
      if (bus.in_ready) begin
        drop_cnt <= (drop_add > DROP_MAX - drop_cnt) ? DROP_MAX : drop_cnt + drop_add;
      end
    end
  end

endmodule
